// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and captures each fetched {pc, instr} pair into a small skid FIFO that feeds
// decode over a valid/ready handshake. Redirects flush the FIFO and reload the PC.
module if_fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2,
    output logic [15:0] fetch_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_ent_t;

    fetch_ent_t       ent_q [DEPTH];
    fetch_ent_t       wr_ent_d;
    fetch_ent_t       head;

    logic [15:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      fetch_count_q, fetch_count_d;

    logic             pop;
    logic             can_push;
    logic             push;

    // Head entry is exposed combinationally; zeroed while the FIFO is empty.
    always_comb begin
        head        = ent_q[rd_ptr_q];
        id_valid    = (count_q != '0);
        id_pc       = id_valid ? head.pc : 16'h0000;
        id_instr    = id_valid ? head.instr : 16'h0000;
        id_pc_plus2 = id_valid ? (head.pc + 16'd2) : 16'h0000;
        imem_pc     = pc_q;
        fetch_count = fetch_count_q;
    end

    // Next-state: a pop frees a slot in the same cycle, so a full FIFO can
    // still accept a fetch while decode drains it. Redirect overrides all.
    always_comb begin
        pop           = id_valid & id_ready;
        can_push      = (count_q < DEPTH_C) | pop;
        push          = can_push & ~redirect_valid;
        wr_ent_d      = '{pc: pc_q, instr: imem_instr};
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[15:1], 1'b0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d          = pc_q + 16'd2;
                wr_ptr_d      = wr_ptr_q + PTR_W'(1);
                fetch_count_d = fetch_count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Entry storage; contents are only observed through a valid count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[wr_ptr_q] <= wr_ent_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations plus
// randomized ready/redirect/reset traffic against a queue-based reference model.
module tb_if_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: word i holds i+1 for the first two words,
    // then a scrambled value so instr never tracks pc trivially.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        logic [15:0] w;
        w = {1'b0, a[15:1]};
        if (w < 16'd2) return w + 16'd1;
        return w ^ 16'h5A3C;
    endfunction

    assign imem_instr = mem_f(imem_pc);

    if_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus2(id_pc_plus2),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched pairs, a PC and a push counter.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc = RESET_PC;
    logic [15:0] m_fc = 16'h0000;

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC;
        m_fc = 16'h0000;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit pop, can_push;
            pop      = (mq.size() != 0) && id_ready;
            can_push = (mq.size() < DEPTH) || pop;
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & 16'hFFFE;
            end else begin
                if (pop) void'(mq.pop_front());
                if (can_push) begin
                    ent_t e;
                    e.pc    = m_pc;
                    e.instr = mem_f(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 16'd2;
                    m_fc = m_fc + 16'd1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic        ev;
        logic [15:0] epc, ein, ep2;
        ev  = (mq.size() != 0);
        epc = ev ? mq[0].pc : 16'h0000;
        ein = ev ? mq[0].instr : 16'h0000;
        ep2 = ev ? mq[0].pc + 16'd2 : 16'h0000;
        chk("m_id_valid", {15'd0, id_valid}, {15'd0, ev});
        chk("m_id_pc", id_pc, epc);
        chk("m_id_instr", id_instr, ein);
        chk("m_id_pc_plus2", id_pc_plus2, ep2);
        chk("m_imem_pc", imem_pc, m_pc);
        chk("m_fetch_count", fetch_count, m_fc);
    end

    // Caller is just past a rising edge; reset spans one full cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset, ready high: first push at first edge, one per cycle after.
        id_ready = 1'b1;
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_id_valid", {15'd0, id_valid}, 16'd0);
        chk("rst_imem_pc", imem_pc, 16'h0000);
        chk("rst_id_pc", id_pc, 16'h0000);
        chk("rst_fetch_count", fetch_count, 16'd0);
        @(negedge clk);
        chk("a_id_valid", {15'd0, id_valid}, 16'd1);
        chk("a_id_pc", id_pc, 16'h0000);
        chk("a_id_instr", id_instr, 16'h0001);
        chk("a_id_pc_plus2", id_pc_plus2, 16'h0002);
        chk("a_fetch_count", fetch_count, 16'd1);
        @(negedge clk);
        chk("a2_id_pc", id_pc, 16'h0002);
        chk("a2_id_instr", id_instr, 16'h0002);
        chk("a2_fetch_count", fetch_count, 16'd2);

        // Ready low from reset: two pushes then stall at PC 0004.
        @(posedge clk); #1;
        id_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        chk("b_imem_pc", imem_pc, 16'h0004);
        chk("b_id_valid", {15'd0, id_valid}, 16'd1);
        chk("b_id_pc", id_pc, 16'h0000);
        chk("b_fetch_count", fetch_count, 16'd2);
        // One cycle of ready while full: push and pop together.
        @(posedge clk); #1;
        id_ready = 1'b1;
        @(posedge clk); #1;
        id_ready = 1'b0;
        @(negedge clk);
        chk("b_full_id_pc", id_pc, 16'h0002);
        chk("b_full_imem_pc", imem_pc, 16'h0006);
        chk("b_full_fetch_count", fetch_count, 16'd3);
        @(negedge clk);
        chk("b_stall_imem_pc", imem_pc, 16'h0006);
        chk("b_stall_id_pc", id_pc, 16'h0002);

        // Redirect with two entries held; bit 0 of target is dropped.
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("c_imem_pc", imem_pc, 16'h0040);
        chk("c_id_valid", {15'd0, id_valid}, 16'd0);
        chk("c_fetch_count", fetch_count, 16'd3);
        @(negedge clk);
        chk("c_id_pc", id_pc, 16'h0040);
        chk("c_id_instr", id_instr, 16'h5A1C);
        chk("c2_fetch_count", fetch_count, 16'd4);

        // PC wrap at FFFE.
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        id_ready       = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_imem_pc", imem_pc, 16'hFFFE);
        @(negedge clk);
        chk("d_id_pc", id_pc, 16'hFFFE);
        chk("d_id_pc_plus2", id_pc_plus2, 16'h0000);
        chk("d_imem_pc_wrap", imem_pc, 16'h0000);
        @(negedge clk);
        chk("d_id_pc_wrap", id_pc, 16'h0000);

        // Asynchronous reset mid-stream with the FIFO full.
        @(posedge clk); #1;
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("e_id_valid", {15'd0, id_valid}, 16'd0);
        chk("e_imem_pc", imem_pc, RESET_PC);
        chk("e_fetch_count", fetch_count, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 16'hFFF8 | 16'($urandom_range(0, 7));
            else
                redirect_pc = 16'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                redirect_valid = 1'b0;
                do_reset();
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
